// File: rtl/siso_llr_framer.sv
// siso_llr_framer: collects one block of (sys, par, ext) LLR triples into a
// single bank, then replays it to the SISO core forward, reverse, or
// forward-then-reverse. Frames with a misplaced or missing last marker are
// dropped and flagged on frame_err_o.
module siso_llr_framer #(
  parameter int SYS_W   = 7,
  parameter int PAR_W   = 7,
  parameter int EXT_W   = 10,
  parameter int BLK_LEN = 4,
  localparam int IDX_W  = $clog2(BLK_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_last_i,
  input  logic [SYS_W-1:0] sys_i,
  input  logic [PAR_W-1:0] par_i,
  input  logic [EXT_W-1:0] ext_i,
  input  logic [1:0]       dir_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SYS_W-1:0] sys_o,
  output logic [PAR_W-1:0] par_o,
  output logic [EXT_W-1:0] ext_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_pass_o,
  output logic             out_last_o,
  output logic             frame_err_o
);

  localparam int W = SYS_W + PAR_W + EXT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(BLK_LEN - 2);
  localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

  typedef enum logic [1:0] {FILL, DRAIN0, DRAIN1} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
  logic [1:0]       mode_reg, mode_next;
  logic             in_ready_reg;
  logic             out_valid_reg, out_valid_next;
  logic             out_pass_reg, out_pass_next;
  logic             out_last_reg, out_last_next;
  logic             frame_err_reg, frame_err_next;
  logic [IDX_W-1:0] out_idx_reg, out_idx_next;
  logic [W-1:0]     out_word_reg;
  logic [W-1:0]     mem [BLK_LEN];
  logic [W-1:0]     in_word;
  logic             accept, out_hs, load, bypass;
  logic [1:0]       eff_mode;

  assign in_word  = {sys_i, par_i, ext_i};
  assign accept   = in_valid_i & in_ready_reg;
  assign out_hs   = out_valid_reg & out_ready_i;
  // Mode is taken from the input on the first triple, from the latch after.
  assign eff_mode = (wr_idx_reg == '0) ? ((dir_mode_i == 2'd3) ? 2'd0 : dir_mode_i)
                                       : mode_reg;

  // Next-state, write-index and output-sequencing decisions.
  always_comb begin
    state_next     = state_reg;
    wr_idx_next    = wr_idx_reg;
    mode_next      = mode_reg;
    frame_err_next = 1'b0;
    out_valid_next = out_valid_reg;
    out_pass_next  = out_pass_reg;
    out_last_next  = out_last_reg;
    out_idx_next   = out_idx_reg;
    load           = 1'b0;
    bypass         = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (wr_idx_reg == '0) mode_next = eff_mode;
          if (in_last_i != (wr_idx_reg == LAST_IDX)) begin
            frame_err_next = 1'b1;
            wr_idx_next    = '0;
          end else if (in_last_i) begin
            state_next     = DRAIN0;
            wr_idx_next    = '0;
            load           = 1'b1;
            out_valid_next = 1'b1;
            out_pass_next  = 1'b0;
            out_last_next  = 1'b0;
            if (eff_mode == 2'd1) begin
              // Reverse starts on the triple being written this very cycle.
              out_idx_next = LAST_IDX;
              bypass       = 1'b1;
            end else begin
              out_idx_next = '0;
            end
          end else begin
            wr_idx_next = wr_idx_reg + ONE_IDX;
          end
        end
      end
      DRAIN0, DRAIN1: begin
        if (out_hs) begin
          if (out_last_reg) begin
            state_next     = FILL;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            out_pass_next  = 1'b0;
            out_idx_next   = '0;
          end else begin
            load = 1'b1;
            if (state_reg == DRAIN0 && mode_reg != 2'd1) begin
              if (out_idx_reg == LAST_IDX) begin
                // End of the alpha pass in mode 2: turn around without a bubble.
                state_next    = DRAIN1;
                out_pass_next = 1'b1;
                out_idx_next  = LAST_IDX;
                out_last_next = 1'b0;
              end else begin
                out_idx_next  = out_idx_reg + ONE_IDX;
                out_last_next = (out_idx_reg == PENULT_IDX) && (mode_reg != 2'd2);
              end
            end else begin
              out_idx_next  = out_idx_reg - ONE_IDX;
              out_last_next = (out_idx_reg == ONE_IDX);
            end
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= FILL;
    else       state_reg <= state_next;
  end

  // Control and output-flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_idx_reg    <= '0;
      mode_reg      <= 2'd0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pass_reg  <= 1'b0;
      out_last_reg  <= 1'b0;
      out_idx_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      wr_idx_reg    <= wr_idx_next;
      mode_reg      <= mode_next;
      in_ready_reg  <= (state_next == FILL);
      out_valid_reg <= out_valid_next;
      out_pass_reg  <= out_pass_next;
      out_last_reg  <= out_last_next;
      out_idx_reg   <= out_idx_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Bank write port.
  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_idx_reg] <= in_word;
  end

  // Registered bank read into the output data register.
  always_ff @(posedge clk_i) begin
    if (rst_i)     out_word_reg <= '0;
    else if (load) out_word_reg <= bypass ? in_word : mem[out_idx_next];
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_pass_o  = out_pass_reg;
  assign out_last_o  = out_last_reg;
  assign out_idx_o   = out_idx_reg;
  assign frame_err_o = frame_err_reg;
  assign sys_o       = out_word_reg[W-1 -: SYS_W];
  assign par_o       = out_word_reg[EXT_W +: PAR_W];
  assign ext_o       = out_word_reg[0 +: EXT_W];

endmodule
